// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared constants for the shift-and-add multiplier family:
// FSM state encodings and the number of add/shift steps per operation.
package shift_add_mult_ctrl_pkg;

    localparam int OPERAND_W = 4;
    localparam int PRODUCT_W = 8;

    // Legacy-compatible 2-bit state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One add/shift step per multiplier bit
    localparam logic [2:0] CALC_CYCLES = 3'd4;

endpackage

// File: rtl/shift_add_mult_ctrl_rca.sv
// 4-bit ripple-carry adder used as the datapath adder of the multiplier.
module rca_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    // One full adder per bit, carry rippling upward
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[4];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential 4x4 unsigned shift-and-add multiplier with IDLE/CALC/DONE control.
// The product is the concatenation {A,Q}; after four add/shift steps it holds M*Q.
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [OPERAND_W-1:0] multiplicand,
    input  logic [OPERAND_W-1:0] multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [PRODUCT_W-1:0] product
);

    logic [1:0]           state_reg, state_next;
    logic [OPERAND_W-1:0] a_reg, a_next;
    logic                 c_reg, c_next;
    logic [OPERAND_W-1:0] q_reg, q_next;
    logic [OPERAND_W-1:0] m_reg, m_next;
    logic [2:0]           cnt_reg, cnt_next;

    logic [OPERAND_W-1:0] adder_sum;
    logic                 adder_cout;
    logic [OPERAND_W-1:0] a_step;
    logic                 c_step;

    // The only arithmetic on A: A + M with no carry in
    rca_4_bit u_adder (
        .a    (a_reg),
        .b    (m_reg),
        .cin  (1'b0),
        .sum  (adder_sum),
        .cout (adder_cout)
    );

    // Conditional add: take the sum when the current multiplier LSB is set.
    // C is always zero entering a step (cleared on capture and by every shift),
    // so {c_reg,a_reg} is the no-add value {0,A}.
    always_comb begin
        if (q_reg[0]) begin
            c_step = adder_cout;
            a_step = adder_sum;
        end else begin
            c_step = c_reg;
            a_step = a_reg;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        c_next     = c_reg;
        q_next     = q_reg;
        m_next     = m_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    m_next     = multiplicand;
                    q_next     = multiplier;
                    a_next     = '0;
                    c_next     = 1'b0;
                    cnt_next   = '0;
                    state_next = ST_CALC;
                end else if (state_reg == ST_DONE) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                // Shift {C,A,Q} right by one after the conditional add
                c_next   = 1'b0;
                a_next   = {c_step, a_step[OPERAND_W-1:1]};
                q_next   = {a_step[0], q_reg[OPERAND_W-1:1]};
                cnt_next = cnt_reg + 3'd1;
                if (cnt_reg == CALC_CYCLES - 3'd1) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // All state registers, cleared immediately by the async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            c_reg     <= 1'b0;
            q_reg     <= '0;
            m_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            c_reg     <= c_next;
            q_reg     <= q_next;
            m_reg     <= m_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign busy    = (state_reg == ST_CALC);
    assign done    = (state_reg == ST_DONE);
    assign product = {a_reg, q_reg};

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: directed vector table,
// hand-written multi-cycle sequences and an exhaustive operand sweep.
module tb_shift_add_mult_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[8];

    shift_add_mult_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full operation: start pulse, 4 busy cycles, 1 done cycle, then idle.
    // Operand inputs are scrambled while busy to show they are not re-sampled.
    task automatic do_mult(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = ~m;
        multiplier   = ~q;
        for (int i = 0; i < 4; i++) begin
            chk("busy_calc", {7'd0, busy}, 8'd1);
            chk("done_calc", {7'd0, done}, 8'd0);
            @(negedge clk);
        end
        chk("done_pulse", {7'd0, done}, 8'd1);
        chk("busy_done", {7'd0, busy}, 8'd0);
        chk("product", product, exp);
        @(negedge clk);
        chk("done_cleared", {7'd0, done}, 8'd0);
        chk("product_hold", product, exp);
        $display("mult %h * %h -> product %h (expected %h)", m, q, product, exp);
    endtask

    initial begin
        vecs[0] = '{4'hF, 4'hF, 8'hE1};
        vecs[1] = '{4'h6, 4'h7, 8'h2A};
        vecs[2] = '{4'h9, 4'h0, 8'h00};
        vecs[3] = '{4'h0, 4'h9, 8'h00};
        vecs[4] = '{4'h1, 4'h1, 8'h01};
        vecs[5] = '{4'h8, 4'h8, 8'h40};
        vecs[6] = '{4'hA, 4'hB, 8'h6E};
        vecs[7] = '{4'hF, 4'h1, 8'h0F};

        start        = 1'b0;
        multiplicand = 4'h0;
        multiplier   = 4'h0;
        rst_n        = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_done", {7'd0, done}, 8'd0);
        chk("reset_product", product, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {7'd0, busy}, 8'd0);

        // Directed vector table
        for (int v = 0; v < 8; v++) begin
            do_mult(vecs[v].m, vecs[v].q, vecs[v].p);
        end

        // start pulse during CALC is ignored
        @(negedge clk);
        start = 1'b1; multiplicand = 4'h3; multiplier = 4'h5;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy1", {7'd0, busy}, 8'd1);
        @(negedge clk);
        chk("ign_busy2", {7'd0, busy}, 8'd1);
        start = 1'b1; multiplicand = 4'hF; multiplier = 4'hF;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy3", {7'd0, busy}, 8'd1);
        @(negedge clk);
        chk("ign_busy4", {7'd0, busy}, 8'd1);
        @(negedge clk);
        chk("ign_done", {7'd0, done}, 8'd1);
        chk("ign_product", product, 8'h0F);
        @(negedge clk);
        chk("ign_single_done", {7'd0, done}, 8'd0);
        chk("ign_no_restart", {7'd0, busy}, 8'd0);
        $display("ignored-start sequence: product %h (expected 0f)", product);

        // Back-to-back with start held high: new operands at each DONE cycle
        @(negedge clk);
        start = 1'b1; multiplicand = vecs[0].m; multiplier = vecs[0].q;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                chk("b2b_busy", {7'd0, busy}, 8'd1);
                chk("b2b_nodone", {7'd0, done}, 8'd0);
                @(negedge clk);
            end
            chk("b2b_done", {7'd0, done}, 8'd1);
            chk("b2b_product", product, vecs[k].p);
            $display("back-to-back %0d: product %h (expected %h)", k, product, vecs[k].p);
            if (k < 3) begin
                multiplicand = vecs[k+1].m;
                multiplier   = vecs[k+1].q;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_end_busy", {7'd0, busy}, 8'd0);
        chk("b2b_end_done", {7'd0, done}, 8'd0);

        // Reset in the second CALC cycle aborts without a done pulse
        @(negedge clk);
        start = 1'b1; multiplicand = 4'hF; multiplier = 4'hF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_pre_busy", {7'd0, busy}, 8'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_product", product, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_done", {7'd0, done}, 8'd0);
        end
        rst_n = 1'b1;
        $display("reset abort: busy %0d done %0d product %h", busy, done, product);
        do_mult(4'hA, 4'hB, 8'h6E);

        // Exhaustive sweep against the arithmetic reference
        for (int m = 0; m < 16; m++) begin
            for (int q = 0; q < 16; q++) begin
                logic [7:0] exp;
                exp = 8'(m * q);
                do_mult(4'(m), 4'(q), exp);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/shift_add_mult_ctrl.md
SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits, product width at 8 bits.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a multiplication; sampled on rising clk edges only in IDLE or DONE.
REQ-005 multiplicand  input  4  unsigned operand M; captured on an accepted start.
REQ-006 multiplier  input  4  unsigned operand Q; captured on an accepted start.
REQ-007 busy  output  1  high while state is CALC.
REQ-008 done  output  1  single-cycle pulse, high exactly while state is DONE.
REQ-009 product  output  8  unsigned M*Q result; valid from DONE until the next accepted start.

Function
REQ-010 FSM states: IDLE, CALC, DONE; 2-bit encoding; no other reachable states.
REQ-011 IDLE: start=1 at an edge -> capture M and Q, clear accumulator A[3:0] and carry C, clear bit counter, go to CALC; start=0 -> remain IDLE.
REQ-012 CALC, each edge: if Q[0]=1 then {C,A} = A + M through the adder (cin=0), else {C,A} = {0,A}; then {C,A,Q} shifts right one bit; bit counter increments.
REQ-013 CALC SHALL last exactly 4 edges; on the 4th edge (counter 3->4), go to DONE.
REQ-014 Latency: start sampled at edge 0 -> done high in the cycle after edge 4, regardless of operand values (including zero operands).
REQ-015 product SHALL equal {A,Q} once DONE is reached; result is exact for all 256 operand pairs (max 15*15 = 0xE1, no overflow).
REQ-016 DONE: lasts one cycle; start=1 at that edge -> accept new operands and go directly to CALC (back-to-back); start=0 -> go to IDLE.
REQ-017 start during CALC SHALL be ignored; operands are not re-captured and the cycle count is unchanged.
REQ-018 multiplicand/multiplier changes after capture SHALL have no effect on the running operation.
REQ-019 product SHALL hold its last value in IDLE; during CALC it shows intermediate {A,Q} and is not valid.
REQ-020 busy and done SHALL never be high simultaneously.

Reset
REQ-021 rst_n low SHALL immediately (without clk) force state=IDLE, A=0, C=0, Q=0, M=0, counter=0, busy=0, done=0, product=0.
REQ-022 Reset asserted mid-CALC SHALL abort the operation; no done pulse is produced for it.
REQ-023 After rst_n deasserts, the first edge with start=1 SHALL be accepted normally.

Structure
REQ-024 State encodings (IDLE=0, CALC=1, DONE=2) and the cycle count constant (4) SHALL live in a shared package/header for the multiplier family.
REQ-025 The block SHALL instantiate exactly one rca_4_bit as its adder (a=A, b=M, cin=0, cout->C next); no other arithmetic "+" on A.
REQ-026 All registers SHALL be in one clocked process sensitive to posedge clk and negedge rst_n; next-state logic combinational.

Verification
REQ-027 M=0xF, Q=0xF, start one cycle -> busy high 4 cycles, done pulse in cycle 5, product=0xE1.
REQ-028 M=0x6, Q=0x7 -> product=0x2A; then M=0x9, Q=0x0 -> product=0x00 with identical 5-cycle latency.
REQ-029 Start M=0x3,Q=0x5; pulse start with M=0xF,Q=0xF during CALC -> ignored, product=0x0F, single done pulse.
REQ-030 start held high continuously with new operands at each DONE edge -> back-to-back operations, done every 5th cycle, each product correct.
REQ-031 Drop rst_n during 2nd CALC cycle -> outputs 0 immediately, no done; next start M=0xA,Q=0xB -> product=0x6E.
REQ-032 Exhaustive sweep of all 256 operand pairs against a reference model -> zero mismatches.
